blink_inv_round_iter: RTL and testbench
=======================================

// Module: blink_inv_round_iter
// PURPOSE
//   Iterative Blink-128 decryption datapath: one inverse round per clock.
//   Inverse round = InvShuffleCells -> XOR tk -> InvMixColumns -> InvSubCells,
//   undoing the forward round R (SubCells -> MixColumns_AddKey -> ShuffleCells).
//   Sits behind the key-schedule store; walks round tweakeys in reverse order
//   and exposes valid/ready handshakes on both the ciphertext and plaintext side.
// PARAMETERS
//   NR       16   number of inverse rounds applied per block (>=1)
//   IDX_W    5    width of round-key index, >= clog2(NR)
// PORTS
//   clk       in   1     system clock, rising edge
//   rst_n     in   1     asynchronous active-low reset
//   in_valid  in   1     ciphertext block offered
//   in_ready  out  1     block accepted when in_valid & in_ready
//   in_data   in   128   ciphertext
//   rk_idx    out  IDX_W round index requested from key store
//   rk_tk     in   128   tweakey for rk_idx, combinational, same cycle
//   out_valid out  1     plaintext valid
//   out_ready in   1     downstream accepts when out_valid & out_ready
//   out_data  out  128   plaintext
// BEHAVIOUR
//   Reset (async assert, sync release): state=IDLE, in_ready=1, out_valid=0,
//   out_data=0, rk_idx=0, state register and round counter cleared.
//   FSM IDLE / RUN / DONE:
//   - IDLE: in_ready=1. On in_valid: st<=in_data, cnt<=NR-1, ->RUN.
//   - RUN: in_ready=0; rk_idx=cnt; st<=InvRound(st, rk_tk) each cycle;
//     cnt decrements; when round with cnt==0 executes -> DONE.
//   - DONE: out_valid=1, out_data=st (held stable). On out_ready:
//     out_valid drops next cycle, ->IDLE.
//   - rk_idx outside RUN is 0; key store must not be assumed to see it.
//   Latency: accept at edge t -> out_valid high after edge t+NR. Throughput
//   one block per NR+2 cycles with out_ready tied high (no IDLE/DONE overlap).
//   Backpressure: DONE holds indefinitely; out_data must not change while
//   out_valid=1 & out_ready=0. in_valid in RUN/DONE is ignored (not queued).
//   Round order: tweakeys consumed NR-1 down to 0, i.e. reverse of the
//   encryption schedule; rk_tk for index k is the key R used at round k.
//   InvRound layers are pure functions of 128-bit state, bit-exact inverses
//   of ShuffleCells, MixColumns and SubCells; XOR is full-width, no carry.
//   NR=1: RUN lasts exactly one cycle.
//   Reset mid-RUN or mid-DONE: state abandoned, outputs to reset values, no
//   partial result ever presented.
// TESTING
//   1 NR=16, tk[k]=0 all k, pt=128'h0: encrypt via 16x R in model, feed ct
//     -> out_data==128'h0 exactly 16 cycles after accept.
//   2 Random pt/tk vectors (>=1000): R^NR then this block -> out_data==pt;
//     rk_idx sequence per block is 15,14,...,0.
//   3 out_ready=0 for 20 cycles after out_valid -> out_data stable,
//     in_ready=0 throughout, in_valid pulses ignored; release -> IDLE 1 cycle later.
//   4 Back-to-back in_valid=1, out_ready=1 -> one accept every NR+2 cycles,
//     results in order.
//   5 rst_n low at RUN cycle 7 -> out_valid=0, in_ready=1 immediately; next
//     block decrypts correctly.
//   6 NR=1 build: pt=128'hFFFF...FF, tk=128'h0123...CDEF -> out_data==pt
//     one cycle after accept.

Source files
------------

// File: rtl/blink_inv_round_iter_if.sv
// Ciphertext-in / plaintext-out handshake plus the round-key lookup toward the key store.
interface blink_inv_round_iter_if #(
  parameter int IDX_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [127:0]     in_data;
  logic [IDX_W-1:0] rk_idx;
  logic [127:0]     rk_tk;
  logic             out_valid;
  logic             out_ready;
  logic [127:0]     out_data;

  modport master (
    output in_valid, in_data, rk_tk, out_ready,
    input  in_ready, rk_idx, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, rk_tk, out_ready,
    output in_ready, rk_idx, out_valid, out_data
  );
endinterface

// File: rtl/blink_inv_round_iter.sv
// Iterative Blink-128 decryption: one inverse round per clock, round keys walked NR-1 down to 0.
//   state | meaning
//   IDLE  | waiting for a ciphertext block, in_ready high
//   RUN   | applying inverse rounds, rk_idx = remaining round index
//   DONE  | plaintext held on out_data until out_ready
module blink_inv_round_iter #(
  parameter int NR    = 16,
  parameter int IDX_W = 5
) (
  input logic                  clk,
  input logic                  rst_n,
  blink_inv_round_iter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [IDX_W-1:0] CNT_LAST = IDX_W'(NR - 1);

  state_t           state_q, state_d;
  logic [127:0]     st_q;
  logic [IDX_W-1:0] cnt_q;

  function automatic logic [3:0] inv_sbox(input logic [3:0] x);
    case (x)
      4'h0: inv_sbox = 4'h5;  4'h1: inv_sbox = 4'hE;
      4'h2: inv_sbox = 4'hF;  4'h3: inv_sbox = 4'h8;
      4'h4: inv_sbox = 4'hC;  4'h5: inv_sbox = 4'h1;
      4'h6: inv_sbox = 4'h2;  4'h7: inv_sbox = 4'hD;
      4'h8: inv_sbox = 4'hB;  4'h9: inv_sbox = 4'h4;
      4'hA: inv_sbox = 4'h6;  4'hB: inv_sbox = 4'h3;
      4'hC: inv_sbox = 4'h0;  4'hD: inv_sbox = 4'h7;
      4'hE: inv_sbox = 4'h9;  default: inv_sbox = 4'hA;
    endcase
  endfunction

  function automatic logic [127:0] inv_sub(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 32; i++) o[4*i +: 4] = inv_sbox(s[4*i +: 4]);
    return o;
  endfunction

  // Rows a..d (a = top word); forward map is (a^c^d, a, b^c, a^c).
  function automatic logic [127:0] inv_mix(input logic [127:0] s);
    logic [31:0] y0, y1, y2, y3, a, b, c, d;
    {y0, y1, y2, y3} = s;
    a = y1;
    c = y3 ^ y1;
    b = y2 ^ c;
    d = y0 ^ a ^ c;
    return {a, b, c, d};
  endfunction

  // Forward shuffle moves cell i to cell (5*i+3) mod 32; undo by gathering.
  function automatic logic [127:0] inv_shuffle(input logic [127:0] s);
    logic [127:0] o;
    int j;
    o = '0;
    for (int i = 0; i < 32; i++) begin
      j = (5 * i + 3) % 32;
      o[4*i +: 4] = s[4*j +: 4];
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_round(input logic [127:0] s, input logic [127:0] tk);
    return inv_sub(inv_mix(inv_shuffle(s) ^ tk));
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      st_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: if (bus.in_valid) begin
          st_q  <= bus.in_data;
          cnt_q <= CNT_LAST;
        end
        RUN: begin
          st_q <= inv_round(st_q, bus.rk_tk);
          if (cnt_q != '0) cnt_q <= cnt_q - IDX_W'(1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.in_valid) state_d = RUN;
      RUN:     if (cnt_q == '0) state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // out_data is gated so a partially decrypted state never appears on the port.
  always_comb begin
    bus.in_ready  = (state_q == IDLE);
    bus.out_valid = (state_q == DONE);
    bus.rk_idx    = (state_q == RUN) ? cnt_q : '0;
    bus.out_data  = (state_q == DONE) ? st_q : '0;
  end

endmodule

// File: tb/tb_blink_inv_round_iter.sv
// Scoreboard bench: encrypts with a forward-round model, checks the decryptor restores the plaintext.
module tb_blink_inv_round_iter;
  localparam int NR    = 16;
  localparam int IDX_W = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  blink_inv_round_iter_if #(.IDX_W(IDX_W)) bus ();
  blink_inv_round_iter_if #(.IDX_W(1))     bus1 ();

  blink_inv_round_iter #(.NR(NR), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave));
  blink_inv_round_iter #(.NR(1), .IDX_W(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1.slave));

  localparam logic [127:0] TK1 = 128'h0123456789ABCDEF0123456789ABCDEF;

  logic [127:0] tk_mem [32];
  assign bus.rk_tk  = tk_mem[bus.rk_idx];
  assign bus1.rk_tk = TK1;

  int n_vec = 0;
  int n_err = 0;
  logic [127:0] sb_q [$];

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] sbox(input logic [3:0] x);
    logic [63:0] t;
    t = 64'hC56B90AD3EF84712;
    return t[63 - 4*x -: 4];
  endfunction

  function automatic logic [127:0] fwd_round(input logic [127:0] s, input logic [127:0] tk);
    logic [127:0] a, m, o;
    logic [31:0] w0, w1, w2, w3;
    for (int i = 0; i < 32; i++) a[4*i +: 4] = sbox(s[4*i +: 4]);
    {w0, w1, w2, w3} = a;
    m = {w0 ^ w2 ^ w3, w0, w1 ^ w2, w0 ^ w2} ^ tk;
    o = '0;
    for (int i = 0; i < 32; i++) o[4*((5*i+3)%32) +: 4] = m[4*i +: 4];
    return o;
  endfunction

  function automatic logic [127:0] encrypt(input logic [127:0] pt);
    logic [127:0] s;
    s = pt;
    for (int k = 0; k < NR; k++) s = fwd_round(s, tk_mem[k]);
    return s;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic step();
    @(negedge clk);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (!bus.in_ready && n < 50) begin
      step();
      n++;
    end
    chk(tag, 128'(bus.in_ready), 128'(1));
  endtask

  // Accept one block, follow its rk_idx walk, stall out_ready, then drain through the scoreboard.
  task automatic do_block(input logic [127:0] pt, input int stall);
    logic [127:0] held, exp;
    wait_idle("idle_before_accept");
    bus.in_valid = 1'b1;
    bus.in_data  = encrypt(pt);
    sb_q.push_back(pt);
    step();
    bus.in_valid = 1'b0;
    for (int k = 0; k < NR; k++) begin
      chk("rk_idx", 128'(bus.rk_idx), 128'(NR - 1 - k));
      chk("valid_in_run", 128'(bus.out_valid), 128'(0));
      step();
    end
    chk("latency_valid", 128'(bus.out_valid), 128'(1));
    held = bus.out_data;
    for (int s = 0; s < stall; s++) begin
      chk("stall_ready", 128'(bus.in_ready), 128'(0));
      chk("stall_data", bus.out_data, held);
      bus.in_valid = s[0];
      bus.in_data  = rand128();
      step();
    end
    bus.in_valid = 1'b0;
    chk("valid_held", 128'(bus.out_valid), 128'(1));
    bus.out_ready = 1'b1;
    exp = (sb_q.size() > 0) ? sb_q.pop_front() : '0;
    chk("plaintext", bus.out_data, exp);
    step();
    bus.out_ready = 1'b0;
    chk("drop_valid", 128'(bus.out_valid), 128'(0));
    chk("back_idle", 128'(bus.in_ready), 128'(1));
  endtask

  initial begin
    logic [127:0] pts [4];
    logic [127:0] cts [4];
    logic [127:0] exp;
    int idx, outs, cyc, last_acc;
    logic accepted;

    bus.in_valid = 1'b0;  bus.in_data = '0;  bus.out_ready = 1'b0;
    bus1.in_valid = 1'b0; bus1.in_data = '0; bus1.out_ready = 1'b0;
    for (int k = 0; k < 32; k++) tk_mem[k] = '0;

    #2 rst_n = 1'b0;
    #1;
    chk("rst_in_ready", 128'(bus.in_ready), 128'(1));
    chk("rst_out_valid", 128'(bus.out_valid), 128'(0));
    chk("rst_out_data", bus.out_data, 128'h0);
    chk("rst_rk_idx", 128'(bus.rk_idx), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // All-zero tweakeys and plaintext
    do_block(128'h0, 0);

    // Random plaintexts and tweakeys
    for (int b = 0; b < 1000; b++) begin
      for (int k = 0; k < NR; k++) tk_mem[k] = rand128();
      do_block(rand128(), 0);
    end

    // Long backpressure with in_valid pulses
    do_block(rand128(), 20);

    // Back-to-back with both sides always willing
    for (int i = 0; i < 4; i++) begin
      pts[i] = rand128();
      cts[i] = encrypt(pts[i]);
    end
    wait_idle("idle_before_b2b");
    idx = 0; outs = 0; cyc = 0; last_acc = -1;
    bus.in_valid  = 1'b1;
    bus.in_data   = cts[0];
    bus.out_ready = 1'b1;
    while (outs < 4 && cyc < 200) begin
      accepted = 1'b0;
      if (bus.in_valid && bus.in_ready) begin
        if (last_acc >= 0) chk("b2b_gap", 128'(cyc - last_acc), 128'(NR + 2));
        last_acc = cyc;
        sb_q.push_back(pts[idx]);
        idx++;
        accepted = 1'b1;
      end
      if (bus.out_valid) begin
        exp = (sb_q.size() > 0) ? sb_q.pop_front() : '0;
        chk("b2b_plaintext", bus.out_data, exp);
        outs++;
      end
      step();
      cyc++;
      if (accepted) begin
        if (idx < 4) bus.in_data = cts[idx];
        else bus.in_valid = 1'b0;
      end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    chk("b2b_outputs", 128'(outs), 128'(4));
    step();

    // Reset in the middle of RUN
    wait_idle("idle_before_rst");
    bus.in_valid = 1'b1;
    bus.in_data  = encrypt(rand128());
    step();
    bus.in_valid = 1'b0;
    for (int k = 0; k < 7; k++) begin
      chk("rst_run_rk_idx", 128'(bus.rk_idx), 128'(NR - 1 - k));
      step();
    end
    #2 rst_n = 1'b0;
    #1;
    chk("midrun_out_valid", 128'(bus.out_valid), 128'(0));
    chk("midrun_in_ready", 128'(bus.in_ready), 128'(1));
    chk("midrun_out_data", bus.out_data, 128'h0);
    chk("midrun_rk_idx", 128'(bus.rk_idx), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    step();
    for (int k = 0; k < NR; k++) tk_mem[k] = rand128();
    do_block(rand128(), 3);

    // Single-round build
    chk("nr1_in_ready", 128'(bus1.in_ready), 128'(1));
    bus1.in_valid = 1'b1;
    bus1.in_data  = fwd_round({128{1'b1}}, TK1);
    step();
    bus1.in_valid = 1'b0;
    chk("nr1_rk_idx", 128'(bus1.rk_idx), 128'(0));
    chk("nr1_valid_run", 128'(bus1.out_valid), 128'(0));
    step();
    chk("nr1_valid", 128'(bus1.out_valid), 128'(1));
    chk("nr1_plaintext", bus1.out_data, {128{1'b1}});
    bus1.out_ready = 1'b1;
    step();
    bus1.out_ready = 1'b0;
    chk("nr1_drop_valid", 128'(bus1.out_valid), 128'(0));
    chk("nr1_idle", 128'(bus1.in_ready), 128'(1));

    chk("sb_empty", 128'(sb_q.size()), 128'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
